// File: rtl/i2s_tx.sv
// I2S master transmitter: takes stereo pairs over a valid/ready handshake into a
// one-deep shadow register and serialises them MSB-first with one-bit I2S delay.
module i2s_tx #(
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 24,
  parameter int SCLK_HALF = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rht_in,
  input  logic              smpl_vld,
  output logic              smpl_rdy,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDout,
  output logic              underrun
);

  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BIT_W = $clog2(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(SCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic              r_sclk, r_lrclk, r_sdout, r_rdy, r_underrun;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_l, r_hold_r, r_shift_l, r_shift_r;

  logic              w_start, w_div_tc, w_fall, w_frame, w_load, w_capture, w_data_bit;
  logic              w_lr_next;
  logic [BIT_W-1:0]  w_bit_next;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: default first so no path leaves the signal unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_IDLE && r_hold_full) w_state_next = ST_RUN;
  end

  always_comb begin
    w_start    = (r_state == ST_IDLE) && (w_state_next == ST_RUN);
    w_div_tc   = (r_state == ST_RUN) && (r_div == DIV_TC);
    w_fall     = w_div_tc && r_sclk;
    w_bit_next = (r_bit == BIT_LAST) ? '0 : r_bit + BIT_W'(1);
    w_lr_next  = (w_bit_next == '0) ? ~r_lrclk : r_lrclk;
    // Frame boundary: the falling SCLK where LRCLK goes right -> left.
    w_frame    = w_fall && (w_bit_next == '0) && r_lrclk;
    w_load     = w_frame && r_hold_full;
    w_capture  = smpl_vld && r_rdy;
    w_data_bit = (w_bit_next != '0) && (w_bit_next <= DATA_LAST);
  end

  // NOTE: shadow and shift data are reset too, so nothing stale can ever be emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_bit       <= '0;
      r_sclk      <= 1'b0;
      r_lrclk     <= 1'b1;
      r_sdout     <= 1'b0;
      r_rdy       <= 1'b1;
      r_underrun  <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_shift_l   <= '0;
      r_shift_r   <= '0;
    end else begin
      if (w_capture) begin
        r_hold_l <= lft_in;
        r_hold_r <= rht_in;
      end
      r_hold_full <= (r_hold_full && !w_load) || w_capture;
      // Ready drops on the capture edge and rises one cycle after the shadow empties.
      r_rdy       <= !(r_hold_full || w_capture);

      if (w_start) begin
        r_div   <= '0;
        r_bit   <= BIT_LAST;
        r_lrclk <= 1'b1;
      end else if (r_state == ST_RUN) begin
        r_div <= w_div_tc ? '0 : r_div + DIV_W'(1);
        if (w_div_tc) r_sclk <= ~r_sclk;
        if (w_fall) begin
          r_bit   <= w_bit_next;
          r_lrclk <= w_lr_next;
          if (w_frame) begin
            r_shift_l <= r_hold_full ? r_hold_l : '0;
            r_shift_r <= r_hold_full ? r_hold_r : '0;
            if (!r_hold_full) r_underrun <= 1'b1;
            r_sdout <= 1'b0;
          end else if (w_data_bit) begin
            if (w_lr_next) begin
              r_sdout   <= r_shift_r[DATA_W-1];
              r_shift_r <= {r_shift_r[DATA_W-2:0], 1'b0};
            end else begin
              r_sdout   <= r_shift_l[DATA_W-1];
              r_shift_l <= {r_shift_l[DATA_W-2:0], 1'b0};
            end
          end else begin
            r_sdout <= 1'b0;
          end
        end
      end
    end
  end

  assign smpl_rdy = r_rdy;
  assign SCLK     = r_sclk;
  assign LRCLK    = r_lrclk;
  assign SDout    = r_sdout;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a frame-timing model derived from elapsed cycles
// is compared every cycle, plus hand-computed literal checks per scenario.
module tb_i2s_tx;

  localparam int DW = 16;
  localparam int SW = 24;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] lft_in = '0;
  logic [DW-1:0] rht_in = '0;
  logic          smpl_vld = 1'b0;
  logic          smpl_rdy, SCLK, LRCLK, SDout, underrun;

  int n_checks = 0;
  int n_fail   = 0;

  i2s_tx #(.DATA_W(DW), .SLOT_W(SW), .SCLK_HALF(H)) dut (
    .clk(clk), .rst(rst), .lft_in(lft_in), .rht_in(rht_in), .smpl_vld(smpl_vld),
    .smpl_rdy(smpl_rdy), .SCLK(SCLK), .LRCLK(LRCLK), .SDout(SDout), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending pair, current frame words, and cycles elapsed since leaving idle.
  logic          m_run = 1'b0, m_pending = 1'b0, m_rdy = 1'b1, m_under = 1'b0;
  logic          m_wp, m_cap;
  int            m_t = 0;
  logic [DW-1:0] m_hl = '0, m_hr = '0, m_fl = '0, m_fr = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_pending = 1'b0; m_rdy = 1'b1; m_under = 1'b0;
      m_hl = '0; m_hr = '0; m_fl = '0; m_fr = '0;
    end else begin
      m_wp  = m_pending;
      m_cap = smpl_vld && m_rdy;
      if (m_run) m_t++;
      else if (m_wp) begin m_run = 1'b1; m_t = 0; end
      if (m_run && m_t > 0 && m_t % (2*H) == 0 && ((m_t/(2*H) - 1) % (2*SW)) == 0) begin
        if (m_wp) begin m_fl = m_hl; m_fr = m_hr; m_pending = 1'b0; end
        else begin m_fl = '0; m_fr = '0; m_under = 1'b1; end
      end
      if (m_cap) begin m_hl = lft_in; m_hr = rht_in; m_pending = 1'b1; end
      m_rdy = !(m_wp || m_cap);
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    int f, g, k;
    logic e_sclk, e_lr, e_sd;
    logic [DW-1:0] word;
    if (cmp_en) begin
      e_sclk = 1'b0; e_lr = 1'b1; e_sd = 1'b0;
      if (m_run) begin
        e_sclk = ((m_t / H) % 2) == 1;
        f = m_t / (2*H);
        if (f > 0) begin
          g    = (f - 1) / SW;
          k    = (f - 1) % SW;
          e_lr = (g % 2) == 1;
          word = e_lr ? m_fr : m_fl;
          e_sd = (k >= 1 && k <= DW) ? word[DW-k] : 1'b0;
        end
      end
      check("outputs{sclk,lr,sd,rdy,und}", {27'd0, SCLK, LRCLK, SDout, smpl_rdy, underrun},
            {27'd0, e_sclk, e_lr, e_sd, m_rdy, m_under});
    end
  end

  // Collector: (LRCLK, SDout) seen at each rising SCLK, i.e. what the codec samples.
  typedef struct packed { logic lr; logic sd; } rise_t;
  rise_t rq[$];
  logic  prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (SCLK === 1'b1 && prev_sclk === 1'b0) rq.push_back('{lr: LRCLK, sd: SDout});
    prev_sclk = SCLK;
  end

  function automatic logic [23:0] slot_word(input int base);
    logic [23:0] w = '0;
    for (int i = 0; i < SW; i++) w = {w[22:0], rq[base+i].sd};
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1; smpl_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic took = 1'b0;
    int   c = 0;
    lft_in = l; rht_in = r; smpl_vld = 1'b1;
    while (!took && c < 1000) begin took = smpl_rdy; @(negedge clk); c++; end
    smpl_vld = 1'b0;
    check("send_handshake", {31'd0, took}, 32'd1);
  endtask

  task automatic wait_rq(input int n, input string name);
    int c = 0;
    while (rq.size() < n && c < 2000) begin @(negedge clk); c++; end
    check(name, {31'd0, rq.size() >= n}, 32'd1);
  endtask

  task automatic count_idle(input int cycles, input string name);
    int tog = 0, ones = 0;
    logic p = SCLK;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (SCLK !== p) tog++;
      if (SDout !== 1'b0) ones++;
      p = SCLK;
    end
    check({name, "_sclk_toggles"}, tog, 0);
    check({name, "_sdout_ones"}, ones, 0);
  endtask

  initial begin
    int n, falls, first_fall, last_fall, tog;
    logic took, p_lr, p_sclk;

    // Reset and idle
    @(negedge clk);
    do_reset();
    cmp_en = 1'b1;
    check("reset_outputs", {27'd0, SCLK, LRCLK, SDout, smpl_rdy, underrun}, 32'b01010);
    count_idle(200, "idle");
    check("idle_outputs", {27'd0, SCLK, LRCLK, SDout, smpl_rdy, underrun}, 32'b01010);

    // Single pair, then starvation -> underrun on the second frame
    rq.delete();
    send(16'hA5C3, 16'h8001);
    check("rdy_after_capture", {31'd0, smpl_rdy}, 32'd0);
    n = 0;
    while (LRCLK && n < 50) begin @(negedge clk); n++; end
    check("lrclk_fall_latency", n, 9);
    check("rdy_at_fall", {31'd0, smpl_rdy}, 32'd0);
    @(negedge clk);
    check("rdy_after_fall", {31'd0, smpl_rdy}, 32'd1);
    wait_rq(49, "frame1_timeout");
    check("underrun_before_frame2", {31'd0, underrun}, 32'd0);
    wait_rq(97, "frame2_timeout");
    check("underrun_after_frame2", {31'd0, underrun}, 32'd1);
    check("slot_lr_pattern", {26'd0, rq[0].lr, rq[1].lr, rq[24].lr, rq[25].lr, rq[49].lr, rq[73].lr},
          32'b100101);
    check("left1_word", slot_word(1), 32'h52E180);
    check("right1_word", slot_word(25), 32'h400080);
    check("left2_zero", slot_word(49), 32'd0);
    check("right2_zero", slot_word(73), 32'd0);
    tog = 0; p_sclk = SCLK;
    for (int i = 0; i < 4*SW*H; i++) begin
      @(negedge clk);
      if (SCLK !== p_sclk) tog++;
      p_sclk = SCLK;
    end
    check("underrun_sclk_toggles", tog, 96);
    check("underrun_sticky", {31'd0, underrun}, 32'd1);

    // Streaming with back-pressure: vld held high, next pair presented after each handshake
    do_reset();
    rq.delete();
    n = 1; lft_in = 16'(n); rht_in = 16'(-n); smpl_vld = 1'b1;
    falls = 0; first_fall = 0; last_fall = 0; p_lr = LRCLK;
    for (int c = 0; c < 3400 && falls < 9; c++) begin
      took = smpl_rdy;
      @(negedge clk);
      if (took) begin n++; lft_in = 16'(n); rht_in = 16'(-n); end
      if (p_lr === 1'b1 && LRCLK === 1'b0) begin
        if (falls == 0) first_fall = c;
        last_fall = c;
        falls++;
      end
      p_lr = LRCLK;
    end
    check("stream_frames", falls, 9);
    check("lrclk_period_x8", last_fall - first_fall, 8*384);
    check("stream_underrun", {31'd0, underrun}, 32'd0);
    check("stream_left1", slot_word(1), 32'h000080);
    check("stream_right1", slot_word(25), 32'h7FFF80);
    check("stream_left2", slot_word(49), 32'h000100);
    check("stream_right2", slot_word(73), 32'h7FFF00);

    // Mid-frame reset at left-slot bit 10 with a pair pending
    for (int i = 0; i < 80; i++) begin
      took = smpl_rdy;
      @(negedge clk);
      if (took) smpl_vld = 1'b0;
    end
    smpl_vld = 1'b0;
    check("pair_pending_before_rst", {31'd0, smpl_rdy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs", {27'd0, SCLK, LRCLK, SDout, smpl_rdy, underrun}, 32'b01010);
    rst = 1'b0;
    count_idle(500, "post_reset");
    check("post_reset_rdy", {31'd0, smpl_rdy}, 32'd1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Output-side serializer for the equalizer's digital core.
- Accepts processed stereo sample pairs (left/right, signed 16-bit) over a valid/ready handshake and holds one pair in a shadow register.
- Generates I2S master clocks (SCLK, LRCLK) and shifts the pair out MSB-first on SDout to the codec DAC.
- Flags underrun when a frame starts with no new pair available.

Parameters:
- DATA_W, 16: sample width in bits.
- SLOT_W, 24: SCLK periods per channel slot; must be >= DATA_W+1.
- SCLK_HALF, 4: clk cycles per SCLK half-period; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- lft_in  input  DATA_W  signed left sample; stable while smpl_vld high.
- rht_in  input  DATA_W  signed right sample; stable while smpl_vld high.
- smpl_vld  input  1  upstream has a pair on lft_in/rht_in.
- smpl_rdy  output  1  shadow register empty; pair is captured when smpl_vld && smpl_rdy.
- SCLK  output  1  serial bit clock.
- LRCLK  output  1  word select; 0 = left slot, 1 = right slot.
- SDout  output  1  serial data to the codec.
- underrun  output  1  sticky flag; a frame started with an empty shadow register.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. While rst is sampled high, the next edge forces:
  - SCLK=0, LRCLK=1, SDout=0, smpl_rdy=1, underrun=0.
  - Shadow register empty, shift registers zero, counters zero, state IDLE.
- Reset mid-frame has the same effect: any pending pair is discarded and there is no partial-frame completion.
- All outputs are registered.
- Handshake:
  - Capture on the edge where smpl_vld && smpl_rdy: hold_L<=lft_in, hold_R<=rht_in, hold_full<=1.
  - smpl_rdy is registered as !hold_full.
  - smpl_vld while smpl_rdy=0 is ignored; upstream keeps data stable.
- State IDLE:
  - SCLK and LRCLK are static; SDout=0.
  - Leave IDLE for RUN on the first cycle hold_full=1, with div_cnt=0, bit_cnt=SLOT_W-1, LRCLK=1.
- State RUN:
  - div_cnt counts 0..SCLK_HALF-1; at terminal count SCLK toggles and div_cnt wraps.
  - All data and LRCLK changes occur on SCLK falling transitions (the clk edge where SCLK goes 1->0). The codec samples on SCLK rising.
  - On each falling transition, bit_cnt increments modulo SLOT_W.
  - On wrap to 0, LRCLK toggles.
- Frame boundary: the falling transition where LRCLK goes 1->0.
  - If hold_full: shift_L/shift_R <= hold_L/hold_R and hold_full<=0, so smpl_rdy=1 on the following cycle.
  - Else: shift registers are loaded with 0 and underrun<=1. underrun stays 1 until rst.
- First boundary after IDLE->RUN occurs 2*SCLK_HALF cycles after the transition.
- Slot bit mapping (I2S one-bit delay), for bit_cnt=k within a slot, SDout is:
  - k=0: 0.
  - k=1..DATA_W: data bit [DATA_W-k] (MSB first).
  - k>DATA_W: 0.
- Left slot uses shift_L; right slot uses shift_R.
- Frame period is 4*SLOT_W*SCLK_HALF clk cycles (384 at defaults).
- Simultaneous capture and frame load in the same cycle cannot occur, because a capture requires hold_full=0. Capture during the cycle hold_full clears is taken on the next cycle.
- RUN never returns to IDLE except via rst.
- Underrun does not stop the clocks; a zero frame is transmitted.

Test Plan:
- Reset / idle:
  - Stimulus: rst=1 for 2 cycles, then smpl_vld=0 for 200 cycles.
  - Required: SCLK=0, LRCLK=1, SDout=0, smpl_rdy=1, underrun=0 throughout; no SCLK toggles.
- Single pair:
  - Stimulus: lft_in=16'hA5C3, rht_in=16'h8001, one vld cycle.
  - Required: smpl_rdy=0 next cycle. LRCLK falls 8 cycles after RUN entry.
  - Left slot SDout at rising SCLK: 0, 1010010111000011, then 7 zeros.
  - Right slot: 0, 1000000000000001, then 7 zeros.
  - smpl_rdy returns to 1 one cycle after the LRCLK fall.
- Streaming:
  - Stimulus: source presents incrementing pairs (L=n, R=-n) whenever smpl_rdy=1, for 8 frames.
  - Required: each pair serialized exactly once and in order; LRCLK period 384 cycles; underrun=0.
- Underrun:
  - Stimulus: one pair, then smpl_vld=0.
  - Required: second frame is all zeros; underrun rises at the second frame boundary and stays 1; SCLK keeps toggling.
- Back-pressure:
  - Stimulus: smpl_vld held high with a new pair while smpl_rdy=0.
  - Required: no capture until smpl_rdy=1; captured value equals the value presented at that edge; no duplication or loss.
- Mid-frame reset:
  - Stimulus: assert rst at left-slot bit_cnt=10 with a pair pending.
  - Required: next cycle all outputs at reset values and state IDLE; the pending pair is never transmitted.
